mii_frame_loopback: RTL and testbench

- Multi-slot frame store-and-replay engine, system-clock domain.
- Accepts decoded MII receive bytes (post-SFD, one byte per strobe), stores whole frames in a ring of fixed-size slots with per-slot length, and replays them in FIFO order to the MII transmit encoder over a valid/ready byte handshake.
- Generalises the single-buffer capture/replay path: parametrised slot count and slot size, per-frame length tracking, drop/truncation accounting, auto or manual replay mode.

---
 rtl/mii_frame_loopback.sv | 258 +++++++++++++++++++++++++
 tb/tb_mii_frame_loopback.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_frame_loopback.sv
// ---------------------------------------------------------------------------
// mii_frame_loopback
//
// Multi-slot frame store-and-replay engine. Decoded MII receive bytes are
// written into a ring of fixed-size slots, each with its own length. Whole
// frames are then replayed in FIFO order to the MII transmit encoder over a
// valid/ready byte handshake. Replay starts automatically (i_auto=1) or on a
// rising edge of i_send.
//
// Optional build macro: LB_MAC_SWAP_EN
//   When defined, frames of 12 bytes or more are replayed with the first two
//   6-byte fields exchanged (destination/source MAC swap). When undefined,
//   frames are replayed verbatim.
//
// Ports:
//   i_clk, i_reset         system clock, asynchronous active-high reset
//   rx_valid/data/last     receive byte stream (post-SFD), one byte per strobe
//   rx_error               marks a corrupt byte; the frame is dropped at rx_last
//   tx_valid/data/last     replay byte stream towards the encoder
//   tx_ready               encoder accepts the current byte
//   i_auto, i_send         replay mode select and manual replay request
//   o_count                committed frames waiting for replay
//   o_drops                saturating count of dropped frames (full or error)
//   o_trunc                sticky flag: a frame was longer than SLOT_BYTES
//   i_dbg_addr, o_dbg_data debug read of the newest committed slot (1 cycle)
// ---------------------------------------------------------------------------
module mii_frame_loopback #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 256,
  parameter int CNT_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_last,
  input  logic                          rx_error,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_last,
  input  logic                          tx_ready,
  input  logic                          i_auto,
  input  logic                          i_send,
  output logic [$clog2(SLOTS+1)-1:0]    o_count,
  output logic [CNT_W-1:0]              o_drops,
  output logic                          o_trunc,
  input  logic [$clog2(SLOT_BYTES)-1:0] i_dbg_addr,
  output logic [7:0]                    o_dbg_data
);

  localparam int SW    = $clog2(SLOTS);
  localparam int OW    = $clog2(SLOT_BYTES);
  localparam int LW    = OW + 1;
  localparam int CW    = $clog2(SLOTS + 1);
  localparam int DEPTH = SLOTS * SLOT_BYTES;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} r_state_t;

  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] slot_len [SLOTS];

  // write side
  w_state_t      w_state, w_next;
  logic [LW-1:0] w_len, len_next, commit_len;
  logic          w_err, err_next;
  logic          mem_we, commit, drop, trunc_set, full;
  logic [OW-1:0] w_off;
  logic [SW-1:0] wr_slot;

  // read side
  r_state_t      r_state, r_next;
  logic [SW-1:0] rd_slot;
  logic [OW-1:0] rd_off, rd_off_next, rd_off_sel, tx_off;
  logic          rd_en, slot_done, arm_clear, armed, send_q, send_rise, trigger;
  logic [LW-1:0] cur_len;
  logic [7:0]    rd_q;
  logic [SW-1:0] newest_slot;

  assign full        = (o_count == CW'(SLOTS));
  assign cur_len     = slot_len[rd_slot];
  assign send_rise   = i_send && !send_q;
  assign trigger     = (o_count != '0) && (i_auto || armed);
  assign newest_slot = wr_slot - SW'(1);

  assign tx_valid = (r_state == R_SEND);
  assign tx_data  = rd_q;
  assign tx_last  = tx_valid && ({1'b0, rd_off} == (cur_len - LW'(1)));

  // Receive FSM: decides where each byte lands and how the frame resolves.
  // A frame resolves (commit or drop) in the same cycle as its rx_last byte,
  // including one-byte frames that arrive while idle.
  always_comb begin
    w_next     = w_state;
    len_next   = w_len;
    err_next   = w_err;
    mem_we     = 1'b0;
    w_off      = '0;
    commit     = 1'b0;
    commit_len = '0;
    drop       = 1'b0;
    trunc_set  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (rx_valid) begin
          if (full) begin
            if (rx_last) drop = 1'b1;
            else         w_next = W_DROP;
          end else begin
            mem_we   = 1'b1;
            len_next = LW'(1);
            err_next = rx_error;
            if (rx_last) begin
              if (rx_error) drop = 1'b1;
              else begin
                commit     = 1'b1;
                commit_len = LW'(1);
              end
            end else begin
              w_next = W_RECV;
            end
          end
        end
      end
      W_RECV: begin
        if (rx_valid) begin
          err_next = w_err | rx_error;
          if (w_len < LW'(SLOT_BYTES)) begin
            mem_we   = 1'b1;
            w_off    = w_len[OW-1:0];
            len_next = w_len + LW'(1);
          end else begin
            trunc_set = 1'b1;
          end
          if (rx_last) begin
            w_next = W_IDLE;
            if (err_next) drop = 1'b1;
            else begin
              commit     = 1'b1;
              commit_len = len_next;
            end
          end
        end
      end
      W_DROP: begin
        if (rx_valid && rx_last) begin
          drop   = 1'b1;
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Receive state, slot pointer and the shared counters. A commit and a
  // replay release in the same cycle cancel out in o_count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      w_state <= W_IDLE;
      w_len   <= '0;
      w_err   <= 1'b0;
      wr_slot <= '0;
      o_count <= '0;
      o_drops <= '0;
      o_trunc <= 1'b0;
    end else begin
      w_state <= w_next;
      w_len   <= len_next;
      w_err   <= err_next;
      if (commit) wr_slot <= wr_slot + SW'(1);
      o_count <= o_count + CW'(commit) - CW'(slot_done);
      if (drop && (o_drops != {CNT_W{1'b1}})) o_drops <= o_drops + CNT_W'(1);
      if (trunc_set) o_trunc <= 1'b1;
    end
  end

  // Byte RAM and per-slot lengths. The write slot is never a counted slot,
  // so it can never collide with the slot being replayed.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[{wr_slot, w_off}] <= rx_data;
    if (commit) slot_len[wr_slot] <= commit_len;
  end

  // Replay FSM. The first byte is read on leaving R_IDLE and held through
  // R_LOAD; afterwards each accepted byte prefetches the next one so that
  // back-to-back transfers have no bubble.
  always_comb begin
    r_next      = r_state;
    rd_en       = 1'b0;
    rd_off_sel  = rd_off;
    rd_off_next = rd_off;
    slot_done   = 1'b0;
    arm_clear   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (trigger) begin
          r_next      = R_LOAD;
          arm_clear   = 1'b1;
          rd_en       = 1'b1;
          rd_off_sel  = '0;
          rd_off_next = '0;
        end
      end
      R_LOAD: r_next = R_SEND;
      R_SEND: begin
        if (tx_ready) begin
          if (tx_last) begin
            r_next    = R_IDLE;
            slot_done = 1'b1;
          end else begin
            rd_off_next = rd_off + OW'(1);
            rd_off_sel  = rd_off_next;
            rd_en       = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

`ifdef LB_MAC_SWAP_EN
  // Exchange offsets 0..5 with 6..11 on frames long enough to carry both.
  always_comb begin
    tx_off = rd_off_sel;
    if (cur_len >= LW'(12)) begin
      if (rd_off_sel < OW'(6))       tx_off = rd_off_sel + OW'(6);
      else if (rd_off_sel < OW'(12)) tx_off = rd_off_sel - OW'(6);
    end
  end
`else
  assign tx_off = rd_off_sel;
`endif

  // Replay registers, send-request edge detector and both RAM read ports.
  // A new i_send edge wins over the clear so a request arriving just as a
  // replay starts is not lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= R_IDLE;
      rd_slot    <= '0;
      rd_off     <= '0;
      armed      <= 1'b0;
      send_q     <= 1'b0;
      rd_q       <= '0;
      o_dbg_data <= '0;
    end else begin
      r_state <= r_next;
      rd_off  <= rd_off_next;
      send_q  <= i_send;
      if (slot_done) rd_slot <= rd_slot + SW'(1);
      if (arm_clear) armed <= 1'b0;
      if (send_rise && (o_count != '0)) armed <= 1'b1;
      if (rd_en) rd_q <= mem[{rd_slot, tx_off}];
      o_dbg_data <= mem[{newest_slot, i_dbg_addr}];
    end
  end

endmodule

// File: tb/tb_mii_frame_loopback.sv
// ---------------------------------------------------------------------------
// tb_mii_frame_loopback
//
// Self-checking bench for mii_frame_loopback with default parameters
// (4 slots of 256 bytes). Stimulus pushes the expected replay bytes into a
// queue as frames are sent; a monitor process pops and compares every byte
// accepted on the tx handshake, and also checks that stalled bytes are held
// and that frames are replayed without gaps. Define LB_MAC_SWAP_EN to check
// the MAC-swap build.
// ---------------------------------------------------------------------------
module tb_mii_frame_loopback;

  localparam int SLOTS      = 4;
  localparam int SLOT_BYTES = 256;
  localparam int CNT_W      = 16;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        rx_valid, rx_last, rx_error;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_last, tx_ready;
  logic [7:0]  tx_data;
  logic        i_auto, i_send;
  logic [2:0]  o_count;
  logic [15:0] o_drops;
  logic        o_trunc;
  logic [7:0]  i_dbg_addr;
  logic [7:0]  o_dbg_data;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   ignore_tx = 1'b0;

  always #5 i_clk = ~i_clk;

  mii_frame_loopback #(
    .SLOTS(SLOTS),
    .SLOT_BYTES(SLOT_BYTES),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_last(rx_last),
    .rx_error(rx_error),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .i_auto(i_auto),
    .i_send(i_send),
    .o_count(o_count),
    .o_drops(o_drops),
    .o_trunc(o_trunc),
    .i_dbg_addr(i_dbg_addr),
    .o_dbg_data(o_dbg_data)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: runs on the falling edge, away from the active edge.
  task automatic monitor_loop();
    exp_t       e;
    logic       held_pending = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_last = 1'b0;
    logic       mid_frame = 1'b0;
    forever begin
      @(negedge i_clk);
      if (ignore_tx || i_reset) begin
        held_pending = 1'b0;
        mid_frame    = 1'b0;
      end else begin
        if (held_pending) begin
          n_cmp++;
          if (!tx_valid || tx_data !== held_data || tx_last !== held_last) begin
            n_bad++;
            $display("[TB] FAIL stall_hold: got valid=%0b data=%02h last=%0b, need valid=1 data=%02h last=%0b",
                     tx_valid, tx_data, tx_last, held_data, held_last);
          end
        end
        if (mid_frame) begin
          n_cmp++;
          if (!tx_valid) begin
            n_bad++;
            $display("[TB] FAIL tx_gap: got tx_valid=0 inside a frame, need 1");
          end
        end
        held_pending = tx_valid && !tx_ready;
        held_data    = tx_data;
        held_last    = tx_last;
        if (tx_valid && tx_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL tx_unexpected: got data=%02h last=%0b, need no byte", tx_data, tx_last);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || tx_last !== e.last) begin
              n_bad++;
              $display("[TB] FAIL tx_byte: got data=%02h last=%0b, need data=%02h last=%0b",
                       tx_data, tx_last, e.data, e.last);
            end
          end
          mid_frame = !tx_last;
        end
      end
    end
  endtask

  // Drive one receive byte for one clock; called at posedge+1.
  task automatic rx_byte(input logic [7:0] d, input logic last, input logic err);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_last  = last;
    rx_error = err;
    @(posedge i_clk);
    #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_error = 1'b0;
  endtask

  // Expected replay: truncated to SLOT_BYTES, optionally MAC-swapped.
  task automatic push_expected(input int n, input logic [7:0] base);
    int   len;
    int   src;
    exp_t e;
    len = (n < SLOT_BYTES) ? n : SLOT_BYTES;
    for (int j = 0; j < len; j++) begin
      src = j;
`ifdef LB_MAC_SWAP_EN
      if (len >= 12) begin
        if (j < 6)       src = j + 6;
        else if (j < 12) src = j - 6;
      end
`endif
      e.data = base + 8'(src);
      e.last = (j == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // Send an n-byte frame base, base+1, ...; err_at < 0 means no error byte.
  task automatic apply_stimulus(input int n, input logic [7:0] base, input int err_at, input bit store);
    if (store) push_expected(n, base);
    for (int i = 0; i < n; i++)
      rx_byte(base + 8'(i), (i == n - 1), (i == err_at));
  endtask

  task automatic pulse_send();
    i_send = 1'b1;
    @(posedge i_clk);
    #1;
    i_send = 1'b0;
  endtask

  // Wait until only 'keep' expected bytes remain and tx is idle.
  task automatic wait_drain(input string name, input int keep, input int max_cycles);
    int k = 0;
    while ((exp_q.size() > keep || tx_valid) && k < max_cycles) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    n_cmp++;
    if (exp_q.size() > keep || tx_valid) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d bytes pending, need %0d", name, exp_q.size(), keep);
      while (exp_q.size() > keep) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    rx_last    = 1'b0;
    rx_error   = 1'b0;
    tx_ready   = 1'b1;
    i_auto     = 1'b1;
    i_send     = 1'b0;
    i_dbg_addr = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_output("rst_tx_last", 32'(tx_last), 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'd0);
    check_output("rst_count", 32'(o_count), 32'd0);
    check_output("rst_drops", 32'(o_drops), 32'd0);
    check_output("rst_trunc", 32'(o_trunc), 32'd0);
    check_output("rst_dbg", 32'(o_dbg_data), 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // 64-byte frame, auto replay, check 2-cycle trigger latency
    $display("[TB] single 64-byte frame, auto mode");
    apply_stimulus(64, 8'h00, -1, 1'b1);
    check_output("t1_count_one", 32'(o_count), 32'd1);
    @(posedge i_clk);
    #1;
    check_output("t1_valid_c1", 32'(tx_valid), 32'd0);
    @(posedge i_clk);
    #1;
    check_output("t1_valid_c2", 32'(tx_valid), 32'd1);
    wait_drain("t1_drain", 0, 500);
    check_output("t1_count_zero", 32'(o_count), 32'd0);

    // Manual mode: five frames into four slots, then replay on request
    $display("[TB] manual mode, overflow drop then 4 sends");
    i_auto = 1'b0;
    for (int f = 0; f < 5; f++)
      apply_stimulus(20, 8'h10 + 8'(f * 32), -1, (f < 4));
    repeat (3) @(posedge i_clk);
    #1;
    check_output("t2_count_full", 32'(o_count), 32'd4);
    check_output("t2_drops", 32'(o_drops), 32'd1);
    check_output("t2_no_auto", 32'(tx_valid), 32'd0);
    for (int f = 0; f < 4; f++) begin
      pulse_send();
      wait_drain("t2_drain", (3 - f) * 20, 500);
      check_output("t2_count_after", 32'(o_count), 32'(3 - f));
    end

    // 300-byte frame truncated to 256, followed by a normal frame
    $display("[TB] oversize frame truncation");
    i_auto = 1'b1;
    check_output("t3_trunc_before", 32'(o_trunc), 32'd0);
    apply_stimulus(300, 8'h00, -1, 1'b1);
    check_output("t3_trunc_set", 32'(o_trunc), 32'd1);
    wait_drain("t3_drain_long", 0, 2000);
    apply_stimulus(16, 8'h40, -1, 1'b1);
    wait_drain("t3_drain_next", 0, 500);
    check_output("t3_trunc_sticky", 32'(o_trunc), 32'd1);
    check_output("t3_count", 32'(o_count), 32'd0);

    // tx_ready toggling every cycle on a 16-byte frame
    $display("[TB] tx_ready backpressure");
    i_auto = 1'b0;
    apply_stimulus(16, 8'hE0, -1, 1'b1);
    pulse_send();
    tx_ready = 1'b0;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || tx_valid); k++) begin
      tx_ready = ~tx_ready;
      @(posedge i_clk);
      #1;
    end
    tx_ready = 1'b1;
    wait_drain("t4_drain", 0, 50);
    check_output("t4_count", 32'(o_count), 32'd0);

    // Error frame dropped, then a one-byte frame
    $display("[TB] error frame and one-byte frame");
    i_auto = 1'b1;
    apply_stimulus(30, 8'h60, 10, 1'b0);
    check_output("t5_count_err", 32'(o_count), 32'd0);
    check_output("t5_drops_err", 32'(o_drops), 32'd2);
    rx_byte(8'hA5, 1'b1, 1'b0);
    exp_q.push_back('{data: 8'hA5, last: 1'b1});
    wait_drain("t5_drain_one", 0, 50);
    check_output("t5_count_one", 32'(o_count), 32'd0);

    // Reset mid-replay and mid-receive, then a clean frame from slot 0
    $display("[TB] reset during replay and receive");
    ignore_tx = 1'b1;
    apply_stimulus(40, 8'h20, -1, 1'b0);
    for (int k = 0; k < 20 && !tx_valid; k++) begin
      @(posedge i_clk);
      #1;
    end
    check_output("t6_replay_started", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 5; i++) rx_byte(8'h90 + 8'(i), 1'b0, 1'b0);
    i_reset = 1'b1;
    #1;
    check_output("t6_rst_valid", 32'(tx_valid), 32'd0);
    check_output("t6_rst_count", 32'(o_count), 32'd0);
    check_output("t6_rst_drops", 32'(o_drops), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset   = 1'b0;
    ignore_tx = 1'b0;
    exp_q.delete();
    i_dbg_addr = 8'd3;
    apply_stimulus(20, 8'hC0, -1, 1'b1);
    wait_drain("t6_drain", 0, 500);
    check_output("t6_count", 32'(o_count), 32'd0);
    check_output("t6_dbg_slot0", 32'(o_dbg_data), 32'hC3);
    check_output("t6_trunc_clear", 32'(o_trunc), 32'd0);

    repeat (3) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
